// File: rtl/joint_cmd_guard_if.sv
// Command path between the host receive logic and the joint guard:
// host-side strobe and raw command in, guarded joint command and status out.
interface joint_cmd_guard_if;
  logic               enable;
  logic signed [31:0] cmd_in;
  logic               cmd_valid;
  logic signed [31:0] jointFreqCmd;
  logic               cmd_active;
  logic               timeout;

  modport master (
    output enable, cmd_in, cmd_valid,
    input  jointFreqCmd, cmd_active, timeout
  );

  modport slave (
    input  enable, cmd_in, cmd_valid,
    output jointFreqCmd, cmd_active, timeout
  );
endinterface

// File: rtl/joint_cmd_guard.sv
// Guard between host command reception and a joint pulse generator.
// Clamps the half-period magnitude, forces a timed stop before any
// direction reversal, and zeroes the command on watchdog expiry or disable.
module joint_cmd_guard #(
  parameter int unsigned min_period      = 12,
  parameter int unsigned max_period      = 48000000,
  parameter int unsigned reverse_hold    = 48000,
  parameter int unsigned watchdog_cycles = 4800000
) (
  input logic             clk,
  input logic             rst_n,
  joint_cmd_guard_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, TIMEOUT} state_t;

  localparam logic [32:0] MIN_MAG   = 33'(min_period);
  localparam logic [32:0] MAX_MAG   = 33'(max_period);
  localparam logic [31:0] HOLD_LAST = 32'(reverse_hold - 1);
  localparam logic [31:0] WD_LIMIT  = 32'(watchdog_cycles);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  state_t             state_q, state_d;
  logic signed [31:0] pending_q, pending_d;
  logic               s1_valid_q, s1_valid_d;
  logic signed [31:0] out_q, out_d;
  logic [31:0]        wd_q, wd_d;
  logic [31:0]        hold_q, hold_d;
  logic               timeout_q, timeout_d;
  logic               active_q, active_d;

  logic [32:0]        mag;
  logic [32:0]        mag_clamped;
  logic signed [31:0] clamped;
  logic [31:0]        wd_inc;
  logic               wd_expire;
  logic               reversal;

  // Clamp the raw command magnitude into the legal range, keeping its sign;
  // the 33-bit magnitude lets -2^31 come out as +2^31 before clamping.
  always_comb begin
    mag = bus.cmd_in[31] ? (33'd0 - {bus.cmd_in[31], bus.cmd_in})
                         : {1'b0, bus.cmd_in};
    if (mag == 33'd0) begin
      mag_clamped = 33'd0;
    end else if (mag < MIN_MAG) begin
      mag_clamped = MIN_MAG;
    end else if (mag > MAX_MAG) begin
      mag_clamped = MAX_MAG;
    end else begin
      mag_clamped = mag;
    end
    clamped = bus.cmd_in[31] ? 32'(33'd0 - mag_clamped) : mag_clamped[31:0];
  end

  // Stage 1: capture the clamped command on each strobe; disable discards it.
  always_comb begin
    pending_d  = pending_q;
    s1_valid_d = 1'b0;
    if (!bus.enable) begin
      pending_d = '0;
    end else if (bus.cmd_valid) begin
      pending_d  = clamped;
      s1_valid_d = 1'b1;
    end
  end

  // Watchdog and reversal helpers shared by the RUN and HOLD decisions.
  always_comb begin
    wd_inc    = (wd_q == CNT_MAX) ? wd_q : wd_q + 32'd1;
    wd_expire = !bus.cmd_valid && (wd_inc >= WD_LIMIT);
    reversal  = (pending_q != '0) && (out_q != '0) && (pending_q[31] != out_q[31]);
  end

  // Next-state and output decisions; disable takes precedence over everything.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    wd_d    = wd_q;
    hold_d  = hold_q;
    if (!bus.enable) begin
      state_d = IDLE;
      out_d   = '0;
      wd_d    = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_d   = '0;
          wd_d    = '0;
          state_d = RUN;
        end
        RUN: begin
          wd_d = bus.cmd_valid ? 32'd0 : wd_inc;
          if (wd_expire) begin
            state_d = TIMEOUT;
            out_d   = '0;
            wd_d    = '0;
          end else if (s1_valid_q) begin
            if (reversal) begin
              out_d   = '0;
              hold_d  = '0;
              state_d = HOLD;
            end else begin
              out_d = pending_q;
            end
          end
        end
        HOLD: begin
          out_d = '0;
          wd_d  = bus.cmd_valid ? 32'd0 : wd_inc;
          if (wd_expire) begin
            state_d = TIMEOUT;
            wd_d    = '0;
          end else if (s1_valid_q && (pending_q == '0)) begin
            state_d = RUN;
          end else if (hold_q == HOLD_LAST) begin
            out_d   = pending_q;
            state_d = RUN;
          end else begin
            hold_d = (hold_q == CNT_MAX) ? hold_q : hold_q + 32'd1;
          end
        end
        TIMEOUT: begin
          out_d = '0;
          wd_d  = '0;
          if (s1_valid_q) begin
            state_d = RUN;
            out_d   = pending_q;
          end
        end
        default: begin
          state_d = IDLE;
          out_d   = '0;
        end
      endcase
    end
    timeout_d = (state_d == TIMEOUT);
    active_d  = (state_d == RUN) && (out_d != '0);
  end

  // State, stage-1 and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      s1_valid_q <= 1'b0;
      out_q      <= '0;
      wd_q       <= '0;
      hold_q     <= '0;
      timeout_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      s1_valid_q <= s1_valid_d;
      out_q      <= out_d;
      wd_q       <= wd_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
      active_q   <= active_d;
    end
  end

  assign bus.jointFreqCmd = out_q;
  assign bus.cmd_active   = active_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_joint_cmd_guard.sv
// Self-checking bench for joint_cmd_guard: directed scenarios with fixed
// expectations, then randomized traffic checked against a timeline model.
module tb_joint_cmd_guard;

  localparam int MIN_P = 12;
  localparam int MAX_P = 1000;
  localparam int REV_H = 20;
  localparam int WD_C  = 100;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  joint_cmd_guard_if bus();

  joint_cmd_guard #(
    .min_period(MIN_P), .max_period(MAX_P),
    .reverse_hold(REV_H), .watchdog_cycles(WD_C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracks absolute cycle numbers instead of counters.
  int    m_out, m_pend;
  bit    m_pnew, m_running, m_timed_out;
  longint m_hold_end, m_last, m_cyc;

  function automatic int clamp_cmd(input int cin);
    longint mag;
    mag = (cin < 0) ? -longint'(cin) : longint'(cin);
    if (mag != 0 && mag < MIN_P) mag = MIN_P;
    if (mag > MAX_P) mag = MAX_P;
    return (cin < 0) ? -int'(mag) : int'(mag);
  endfunction

  task automatic model_reset();
    m_out = 0; m_pend = 0; m_pnew = 0; m_running = 0; m_timed_out = 0;
    m_hold_end = -1; m_last = 0;
  endtask

  task automatic model_step();
    int nxt_pend;
    bit nxt_pnew;
    m_cyc++;
    if (!bus.enable) begin
      model_reset();
      return;
    end
    nxt_pnew = bus.cmd_valid;
    nxt_pend = bus.cmd_valid ? clamp_cmd(bus.cmd_in) : m_pend;
    if (!m_running) begin
      m_running = 1; m_last = m_cyc; m_out = 0;
    end else if (m_timed_out) begin
      if (m_pnew) begin
        m_timed_out = 0; m_out = m_pend; m_last = m_cyc;
      end
    end else if (!bus.cmd_valid && (m_cyc - m_last >= WD_C)) begin
      m_timed_out = 1; m_out = 0; m_hold_end = -1;
    end else begin
      if (bus.cmd_valid) m_last = m_cyc;
      if (m_hold_end >= 0) begin
        if (m_pnew && m_pend == 0) m_hold_end = -1;
        else if (m_cyc == m_hold_end) begin
          m_out = m_pend; m_hold_end = -1;
        end
      end else if (m_pnew) begin
        if (m_pend != 0 && m_out != 0 && ((m_pend < 0) != (m_out < 0))) begin
          m_out = 0; m_hold_end = m_cyc + REV_H;
        end else begin
          m_out = m_pend;
        end
      end
    end
    m_pend = nxt_pend;
    m_pnew = nxt_pnew;
  endtask

  // Advance the model alongside the DUT, including asynchronous clears.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  initial m_cyc = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobe(input int v);
    bus.cmd_in = v;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic go_to(input int v);
    strobe(0);
    tick();
    strobe(v);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_in = '0;
    repeat (3) tick();
    checks++;
    if (bus.jointFreqCmd !== 32'sd0) begin
      errors++; $display("[TB] FAIL reset_out: got %0d expected 0", bus.jointFreqCmd);
    end
    checks++;
    if (bus.cmd_active !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_active: got %b expected 0", bus.cmd_active);
    end
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", bus.timeout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.enable = 1'b1;
    tick();
    strobe(500);
    checks++;
    if (bus.jointFreqCmd !== 32'sd0) begin
      errors++; $display("[TB] FAIL basic_latency: got %0d expected 0", bus.jointFreqCmd);
    end
    tick();
    checks++;
    if (bus.jointFreqCmd !== 32'sd500) begin
      errors++; $display("[TB] FAIL basic_out: got %0d expected 500", bus.jointFreqCmd);
    end
    checks++;
    if (bus.cmd_active !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_active: got %b expected 1", bus.cmd_active);
    end
  endtask

  task automatic test_clamp();
    int ins[5];
    int exps[5];
    ins  = '{5, 5000, 0, -3, int'(32'h8000_0000)};
    exps = '{12, 1000, 0, -12, -1000};
    for (int i = 0; i < 5; i++) begin
      strobe(ins[i]);
      tick();
      checks++;
      if (bus.jointFreqCmd !== exps[i]) begin
        errors++;
        $display("[TB] FAIL clamp_out[%0d]: got %0d expected %0d", i, bus.jointFreqCmd, exps[i]);
      end
      checks++;
      if (bus.cmd_active !== (exps[i] != 0)) begin
        errors++;
        $display("[TB] FAIL clamp_active[%0d]: got %b expected %b", i, bus.cmd_active, exps[i] != 0);
      end
    end
  endtask

  task automatic test_reversal();
    int zero_bad;
    int late_k[2];
    late_k = '{5, 19};
    go_to(500);
    strobe(-300);
    zero_bad = 0;
    for (int k = 0; k < REV_H; k++) begin
      tick();
      if (bus.jointFreqCmd !== 32'sd0) zero_bad++;
    end
    checks++;
    if (zero_bad != 0) begin
      errors++; $display("[TB] FAIL rev_zero_cycles: got %0d nonzero cycles expected 0", zero_bad);
    end
    tick();
    checks++;
    if (bus.jointFreqCmd !== -32'sd300) begin
      errors++; $display("[TB] FAIL rev_apply: got %0d expected -300", bus.jointFreqCmd);
    end
    for (int j = 0; j < 2; j++) begin
      go_to(500);
      strobe(-300);
      tick();
      for (int k = 1; k < REV_H; k++) begin
        bus.cmd_in = -400;
        bus.cmd_valid = (k == late_k[j]);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.jointFreqCmd !== 32'sd0) begin
          errors++; $display("[TB] FAIL rev_mid_zero[%0d]: got %0d expected 0", k, bus.jointFreqCmd);
        end
      end
      tick();
      checks++;
      if (bus.jointFreqCmd !== -32'sd400) begin
        errors++; $display("[TB] FAIL rev_mid_apply[%0d]: got %0d expected -400", j, bus.jointFreqCmd);
      end
    end
    go_to(500);
    strobe(-300);
    tick();
    for (int k = 1; k <= 6; k++) begin
      bus.cmd_in = 0;
      bus.cmd_valid = (k == 5);
      tick();
      bus.cmd_valid = 1'b0;
    end
    checks++;
    if (bus.jointFreqCmd !== 32'sd0 || bus.cmd_active !== 1'b0) begin
      errors++; $display("[TB] FAIL rev_cancel: got %0d/%b expected 0/0", bus.jointFreqCmd, bus.cmd_active);
    end
    strobe(300);
    tick();
    checks++;
    if (bus.jointFreqCmd !== 32'sd300) begin
      errors++; $display("[TB] FAIL rev_cancel_run: got %0d expected 300", bus.jointFreqCmd);
    end
  endtask

  task automatic test_watchdog();
    strobe(500);
    repeat (98) tick();
    checks++;
    if (bus.jointFreqCmd !== 32'sd500 || bus.timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL wd_before: got %0d/%b expected 500/0", bus.jointFreqCmd, bus.timeout);
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL wd_edge99: got %b expected 0", bus.timeout);
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b1 || bus.jointFreqCmd !== 32'sd0 || bus.cmd_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wd_expire: got %b/%0d/%b expected 1/0/0", bus.timeout, bus.jointFreqCmd, bus.cmd_active);
    end
    strobe(200);
    tick();
    checks++;
    if (bus.timeout !== 1'b0 || bus.jointFreqCmd !== 32'sd200 || bus.cmd_active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wd_recover: got %b/%0d/%b expected 0/200/1", bus.timeout, bus.jointFreqCmd, bus.cmd_active);
    end
    strobe(500);
    repeat (99) tick();
    strobe(500);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL wd_race: got %b expected 0", bus.timeout);
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b0 || bus.jointFreqCmd !== 32'sd500) begin
      errors++; $display("[TB] FAIL wd_race_after: got %b/%0d expected 0/500", bus.timeout, bus.jointFreqCmd);
    end
  endtask

  task automatic test_enable_drop();
    bus.enable = 1'b0;
    bus.cmd_in = 700;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.jointFreqCmd !== 32'sd0 || bus.cmd_active !== 1'b0) begin
      errors++; $display("[TB] FAIL en_drop: got %0d/%b expected 0/0", bus.jointFreqCmd, bus.cmd_active);
    end
    tick();
    bus.enable = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus.jointFreqCmd !== 32'sd0) begin
      errors++; $display("[TB] FAIL en_reenable: got %0d expected 0", bus.jointFreqCmd);
    end
    strobe(700);
    tick();
    checks++;
    if (bus.jointFreqCmd !== 32'sd700) begin
      errors++; $display("[TB] FAIL en_restart: got %0d expected 700", bus.jointFreqCmd);
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.jointFreqCmd !== 32'sd0 || bus.cmd_active !== 1'b0) begin
      errors++; $display("[TB] FAIL areset_run: got %0d/%b expected 0/0", bus.jointFreqCmd, bus.cmd_active);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    strobe(700);
    tick();
    strobe(-300);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.jointFreqCmd !== 32'sd0 || bus.cmd_active !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_hold: got %0d/%b/%b expected 0/0/0", bus.jointFreqCmd, bus.cmd_active, bus.timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) tick();
    checks++;
    if (bus.jointFreqCmd !== 32'sd0) begin
      errors++; $display("[TB] FAIL areset_idle: got %0d expected 0", bus.jointFreqCmd);
    end
  endtask

  function automatic int rand_cmd();
    int v;
    case ($urandom_range(0, 5))
      0: v = 0;
      1: v = int'($urandom_range(1, 20));
      2: v = int'($urandom_range(1, 1200));
      3: v = int'($urandom);
      4: v = int'(32'h8000_0000);
      default: v = int'($urandom_range(990, 1010));
    endcase
    if ($urandom_range(0, 1) == 1 && v != int'(32'h8000_0000)) v = -v;
    return v;
  endfunction

  task automatic test_random();
    int dens[4];
    int p;
    bit exp_active;
    dens = '{0, 3, 20, 80};
    p = 20;
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.cmd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) p = dens[$urandom_range(0, 3)];
      bus.enable = ($urandom_range(0, 199) != 0);
      bus.cmd_valid = (int'($urandom_range(0, 99)) < p);
      bus.cmd_in = rand_cmd();
      tick();
      exp_active = m_running && !m_timed_out && (m_out != 0);
      checks++;
      if (bus.jointFreqCmd !== m_out) begin
        errors++; $display("[TB] FAIL rand_out@%0d: got %0d expected %0d", i, bus.jointFreqCmd, m_out);
      end
      checks++;
      if (bus.cmd_active !== exp_active) begin
        errors++; $display("[TB] FAIL rand_active@%0d: got %b expected %b", i, bus.cmd_active, exp_active);
      end
      checks++;
      if (bus.timeout !== m_timed_out) begin
        errors++; $display("[TB] FAIL rand_timeout@%0d: got %b expected %b", i, bus.timeout, m_timed_out);
      end
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_reversal();
    test_watchdog();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
